// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state type and default timing constants for the debounce bank
package debounce_pkg;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_SETTLING = 1'b1
    } db_state_t;

    localparam int DEF_STABLE_CYC = 48000;
    localparam int DEF_RPT_DLY    = 24000000;
    localparam int DEF_RPT_PER    = 4800000;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one debounce channel: synchronizer, settle FSM, optional repeat (DEBOUNCE_AUTOREPEAT_EN)
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CYC = DEF_STABLE_CYC
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int RPT_DLY    = DEF_RPT_DLY,
    parameter int RPT_PER    = DEF_RPT_PER
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    db_state_t       state_q, state_d;

    // Synchronizer, settle FSM and registered pulses; reset aborts any settle in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= DB_STABLE;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    // Accept a new level only after STABLE_CYC further mismatching cycles; any match drops back.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (s2_q != level_q) begin
                    state_d = DB_SETTLING;
                    cnt_d   = '0;
                end
            end
            DB_SETTLING: begin
                if (s2_q == level_q) begin
                    state_d = DB_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    level_d   = ~level_q;
                    press_d   = ~level_q;
                    release_d = level_q;
                    state_d   = DB_STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DB_STABLE;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rfirst_q, rfirst_d;
    logic          rpt_q, rpt_d;
    logic [RW-1:0] rtarget;

    // Repeat counter state; cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b0;
            rpt_q    <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
            rpt_q    <= rpt_d;
        end
    end

    // Count only while the level is held high across the edge; press and release restart it.
    always_comb begin
        rcnt_d   = '0;
        rfirst_d = 1'b0;
        rpt_d    = 1'b0;
        rtarget  = rfirst_q ? RW'(RPT_PER - 1) : RW'(RPT_DLY - 1);
        if (level_q && level_d) begin
            rfirst_d = rfirst_q;
            if (rcnt_q == rtarget) begin
                rpt_d    = 1'b1;
                rfirst_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    assign rpt_o = rpt_q;
`else
    assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of N_CH independent debounce channels; auto-repeat under DEBOUNCE_AUTOREPEAT_EN
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int RPT_DLY    = DEF_RPT_DLY,
    parameter int RPT_PER    = DEF_RPT_PER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_level,
    output logic [N_CH-1:0] rpt_pulse
);

    // Reject parameter sets the channels cannot implement.
    if (N_CH < 1 || N_CH > 32 || STABLE_CYC < 1 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_params
        $error("debounce_bank: illegal parameter set");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CYC (STABLE_CYC)
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ,
            .RPT_DLY    (RPT_DLY),
            .RPT_PER    (RPT_PER)
`endif
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .raw_i     (raw_in[i]),
            .level_o   (level_out[i]),
            .press_o   (press_pulse[i]),
            .release_o (release_pulse[i]),
            .rpt_o     (rpt_pulse[i])
        );
    end

    assign any_level = |level_out;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - randomized, model-checked bench for debounce_bank
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] level_out, press_pulse, release_pulse, rpt_pulse;
    logic         any_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    debounce_bank #(.N_CH(N), .STABLE_CYC(S), .RPT_DLY(RD), .RPT_PER(RP)) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .level_out     (level_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_level     (any_level),
        .rpt_pulse     (rpt_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: raw is seen by the decision logic two edges late; a level flips on the
    // (S+1)-th consecutive edge at which the delayed input disagrees with it.
    logic [N-1:0] m_p1, m_p2, m_lvl, m_press, m_rel, m_rpt;
    int           m_run [N];
    int           m_age [N];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_p1 = '0; m_p2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c] = 0;
                m_age[c] = 0;
            end
        end else begin
            logic [N-1:0] seen, old;
            seen = m_p2;
            m_p2 = m_p1;
            m_p1 = raw_in;
            old  = m_lvl;
            m_press = '0; m_rel = '0; m_rpt = '0;
            for (int c = 0; c < N; c++) begin
                if (seen[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == S + 1) begin
                        m_lvl[c]   = seen[c];
                        m_press[c] = seen[c];
                        m_rel[c]   = ~seen[c];
                        m_run[c]   = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                if (old[c] && m_lvl[c]) begin
                    m_age[c]++;
                    m_rpt[c] = (m_age[c] >= RD) && ((m_age[c] - RD) % RP == 0);
                end else begin
                    m_age[c] = 0;
                end
`else
                m_age[c] = old[c] ? 1 : 0;
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("cmp_level",   32'(level_out),     32'(m_lvl));
            chk("cmp_press",   32'(press_pulse),   32'(m_press));
            chk("cmp_release", 32'(release_pulse), 32'(m_rel));
            chk("cmp_rpt",     32'(rpt_pulse),     32'(m_rpt));
            chk("cmp_any",     32'(any_level),     32'(|m_lvl));
        end
    end

    int rpt_edges[$];
    int p1_cnt = 0;
    always @(negedge clk) begin
        if (rpt_pulse[0] === 1'b1) rpt_edges.push_back(cyc);
        if (press_pulse[1] === 1'b1) p1_cnt++;
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_level",   32'(level_out),     32'h0);
        chk("rst_press",   32'(press_pulse),   32'h0);
        chk("rst_release", 32'(release_pulse), 32'h0);
        chk("rst_rpt",     32'(rpt_pulse),     32'h0);
        chk("rst_any",     32'(any_level),     32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int k, r, d, p, rk, late;
        reset  = 1'b1;
        raw_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_state_level", 32'(level_out), 32'h0);

        // Clean step on channel 0.
        raw_in[0] = 1'b1;
        k = cyc + 1;
        wait_until(k + 9);
        chk("step_level_early", 32'(level_out[0]), 32'h0);
        chk("step_press_early", 32'(press_pulse), 32'h0);
        wait_until(k + 10);
        chk("step_level", 32'(level_out[0]), 32'h1);
        chk("step_press", 32'(press_pulse), 32'h1);
        chk("step_any", 32'(any_level), 32'h1);
        chk("model_step_press", 32'(m_press), 32'h1);
        wait_until(k + 11);
        chk("step_press_once", 32'(press_pulse), 32'h0);

        // Bounce on channel 1: high 3, low 2, then steady high.
        p1_cnt = 0;
        raw_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        raw_in[1] = 1'b0;
        repeat (2) @(negedge clk);
        raw_in[1] = 1'b1;
        r = cyc + 1;
        wait_until(r + 9);
        chk("bounce_early", 32'(press_pulse[1]), 32'h0);
        wait_until(r + 10);
        chk("bounce_press", 32'(press_pulse[1]), 32'h1);
        chk("model_bounce_press", 32'(m_press[1]), 32'h1);
        wait_until(r + 15);
        chk("bounce_count", 32'(p1_cnt), 32'h1);

        // Simultaneous release on channels 2 and 3.
        raw_in[3:2] = 2'b11;
        repeat (15) @(negedge clk);
        raw_in[3:2] = 2'b00;
        k = cyc + 1;
        wait_until(k + 10);
        chk("multi_release", 32'(release_pulse), 32'hc);
        chk("multi_no_press", 32'(press_pulse), 32'h0);
        chk("model_multi_release", 32'(m_rel), 32'hc);

        // Reset in the middle of a settle on channel 0.
        raw_in[0] = 1'b0;
        repeat (15) @(negedge clk);
        raw_in[0] = 1'b1;
        k = cyc + 1;
        wait_until(k + 7);
        pulse_reset();
        d = cyc + 1;
        rpt_edges.delete();
        wait_until(d + 9);
        chk("postrst_early", 32'(press_pulse[0]), 32'h0);
        wait_until(d + 10);
        chk("postrst_press", 32'(press_pulse[0]), 32'h1);
        p = d + 10;

        // Hold for auto-repeat, then release.
        wait_until(p + 32);
        raw_in[0] = 1'b0;
        rk = cyc + 1;
        wait_until(rk + 10);
        chk("rpt_release", 32'(release_pulse[0]), 32'h1);
        repeat (40) @(negedge clk);
        late = 0;
        foreach (rpt_edges[i]) if (rpt_edges[i] >= rk + 10) late++;
        chk("rpt_after_release", 32'(late), 32'h0);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        chk("rpt_count", 32'(rpt_edges.size()), 32'h5);
        if (rpt_edges.size() >= 3) begin
            chk("rpt_first",  32'(rpt_edges[0]), 32'(p + 20));
            chk("rpt_second", 32'(rpt_edges[1]), 32'(p + 25));
            chk("rpt_third",  32'(rpt_edges[2]), 32'(p + 30));
        end
`else
        chk("rpt_none", 32'(rpt_edges.size()), 32'h0);
`endif

        // Randomized traffic: mixed short glitches and long holds, occasional reset.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) raw_in = 4'($urandom_range(0, 15));
                else raw_in = raw_in ^ (4'b1 << $urandom_range(0, 3));
                repeat ($urandom_range(0, 13)) @(negedge clk);
                if ($urandom_range(0, 9) == 0) repeat (40) @(negedge clk);
            end
        end
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 The block SHALL have parameter STABLE_CYC, default 48000: number of consecutive stable synchronized cycles required to accept a new level; legal range is 1 or more.
REQ-003 The block SHALL have parameter RPT_DLY, default 24000000: cycles from a press to the first auto-repeat pulse.
REQ-004 The block SHALL have parameter RPT_PER, default 4800000: cycles between subsequent auto-repeat pulses.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port raw_in, input, N_CH bits: asynchronous, bouncing button levels, one per channel.
REQ-008 The block SHALL have port level_out, output, N_CH bits: debounced level per channel.
REQ-009 The block SHALL have port press_pulse, output, N_CH bits: one-cycle pulse on a debounced 0-to-1 transition.
REQ-010 The block SHALL have port release_pulse, output, N_CH bits: one-cycle pulse on a debounced 1-to-0 transition.
REQ-011 The block SHALL have port any_level, output, 1 bit: OR of level_out.
REQ-012 The block SHALL have port rpt_pulse, output, N_CH bits: one-cycle auto-repeat pulse.

Function
REQ-013 Each channel SHALL pass raw_in through a two-flop synchronizer (s1, s2) before any other logic.
REQ-014 Each channel SHALL run an FSM with states DB_STABLE and DB_SETTLING, plus a saturating counter sized $clog2(STABLE_CYC+1).
REQ-015 In DB_STABLE, when s2 != level_out, the channel SHALL enter DB_SETTLING with cnt=0; otherwise it holds.
REQ-016 In DB_SETTLING, when s2 == level_out (bounce back), the channel SHALL return to DB_STABLE with no output change.
REQ-017 In DB_SETTLING, when s2 != level_out and cnt == STABLE_CYC-1, the channel SHALL invert level_out, assert the matching press_pulse or release_pulse for exactly one cycle, and return to DB_STABLE; otherwise it increments cnt.
REQ-018 Latency SHALL be as follows: for a clean step first sampled at edge k, level_out and the pulse SHALL change at edge k+STABLE_CYC+2.
REQ-019 A raw glitch shorter than STABLE_CYC synchronized cycles SHALL produce no change on any output.
REQ-020 press_pulse and release_pulse SHALL be registered, SHALL be mutually exclusive per channel, and SHALL never fire on consecutive cycles for the same channel.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 any_level SHALL be combinational from the level_out registers.

Reset
REQ-023 Asserting reset SHALL immediately clear s1, s2, level_out, press_pulse, release_pulse, rpt_pulse, all counters and any_level, and SHALL force every FSM to DB_STABLE.
REQ-024 Reset asserted mid-settle SHALL abort the settle with no pulse; an input held high through reset release SHALL produce press_pulse STABLE_CYC+2 edges after release.

Configuration
REQ-025 When DEBOUNCE_AUTOREPEAT_EN is defined, each channel SHALL have a repeat counter: while level_out=1, rpt_pulse SHALL fire RPT_DLY cycles after press_pulse and then every RPT_PER cycles; release or reset SHALL clear the counter, with no pulse in the release cycle.
REQ-026 When DEBOUNCE_AUTOREPEAT_EN is undefined, the rpt_pulse port SHALL remain present, tied to 0, with no repeat counters synthesized.

Structure
REQ-027 Package debounce_pkg SHALL hold typedef db_state_t {DB_STABLE, DB_SETTLING} and the default constants for STABLE_CYC, RPT_DLY and RPT_PER.
REQ-028 Sub-module debounce_ch SHALL implement one channel (synchronizer, FSM, counters); debounce_bank SHALL instantiate N_CH copies via generate and form any_level.

Verification (STABLE_CYC=8, RPT_DLY=20, RPT_PER=5, N_CH=4)
REQ-029 Clean step: raw_in[0] 0->1 sampled at edge 10 -> level_out[0]=1 and press_pulse[0]=1 at edge 20 only; any_level=1 from edge 20.
REQ-030 Bounce: raw_in[1] toggles high 3 cycles, low 2, then high steady -> exactly one press_pulse[1], issued 10 edges after the last rising sample.
REQ-031 Release and multi-channel: channels 2 and 3 released on the same edge -> release_pulse=4'b1100 in one cycle; no press pulses.
REQ-032 Reset mid-settle: reset at cnt=5 while raw_in[0]=1 is held -> all outputs 0 immediately; press_pulse[0] 10 edges after reset deassert.
REQ-033 Auto-repeat (macro defined): hold raw_in[0]=1 -> rpt_pulse[0] at press+20, +25, +30; release -> no further rpt_pulse. With the macro undefined, rpt_pulse stays 0.
